// File: rtl/pwm_clksw_ctrl_pkg.sv
// rtl/pwm_clksw_ctrl_pkg.sv - shared types for the PWM clock-source switch sequencer
package pwm_clksw_ctrl_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } pwm_onoff_t;

  localparam int CLKSW_SEL_W = 2;

  typedef enum logic [2:0] {
    CLKSW_IDLE       = 3'd0,
    CLKSW_WAIT_BOUND = 3'd1,
    CLKSW_WAIT_IDLE  = 3'd2,
    CLKSW_SWITCH     = 3'd3,
    CLKSW_SETTLE     = 3'd4,
    CLKSW_RESTART    = 3'd5
  } clksw_state_t;

endpackage

// File: rtl/pwm_clksw_tmr.sv
// rtl/pwm_clksw_tmr.sv - loadable down-counter shared by the timeout and settle phases
module pwm_clksw_tmr #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Saturates at zero so a disabled timeout (load value 0) never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/pwm_clksw_ctrl.sv
// rtl/pwm_clksw_ctrl.sv - sequences a glitch-free PWM clock-source change:
// wait carrier boundary, force PWM off, wait idle, switch mux, settle, restart.
module pwm_clksw_ctrl
  import pwm_clksw_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W  = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  input  logic [CLKSW_SEL_W-1:0] i_req_sel,
  output logic                   o_req_ready,
  input  pwm_onoff_t             i_user_onoff,
  input  logic                   i_carr_zero,
  input  logic                   i_pwm_idle,
  input  logic [TIMEOUT_W-1:0]   i_timeout_cyc,
  output pwm_onoff_t             o_pwm_onoff,
  output logic [CLKSW_SEL_W-1:0] o_clk_sel_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  clksw_state_t           r_state;
  clksw_state_t           w_state_nxt;
  pwm_onoff_t             r_onoff;
  pwm_onoff_t             w_onoff_nxt;
  logic [CLKSW_SEL_W-1:0] r_clk_sel;
  logic [CLKSW_SEL_W-1:0] r_pend_sel;
  logic                   r_same_done;
  logic                   r_err;
  logic                   r_idle_armed;

  logic                   w_accept;
  logic                   w_same;
  logic                   w_timeout;
  logic                   w_tmr_load;
  logic [TIMEOUT_W-1:0]   w_tmr_val;
  logic                   w_tmr_dec;
  logic                   w_sel_load;
  logic                   w_err_set;
  logic [TIMEOUT_W-1:0]   w_tmr_count;
  logic                   w_tmr_zero;

  assign w_accept  = i_req_valid && (r_state == CLKSW_IDLE);
  assign w_same    = w_accept && (i_req_sel == r_clk_sel);
  assign w_timeout = (i_timeout_cyc != '0) && w_tmr_zero;

  pwm_clksw_tmr #(.W(TIMEOUT_W)) u_tmr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= CLKSW_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Exit conditions are tested before the timeout so they win a same-cycle tie.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLKSW_IDLE: begin
        if (w_accept && !w_same) begin
          w_state_nxt = (i_user_onoff == PWM_OFF) ? CLKSW_SWITCH : CLKSW_WAIT_BOUND;
        end
      end
      CLKSW_WAIT_BOUND: begin
        if (i_user_onoff == PWM_OFF) begin
          w_state_nxt = CLKSW_SWITCH;
        end else if (i_carr_zero) begin
          w_state_nxt = CLKSW_WAIT_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = CLKSW_IDLE;
        end
      end
      CLKSW_WAIT_IDLE: begin
        if (i_pwm_idle && r_idle_armed) begin
          w_state_nxt = CLKSW_SWITCH;
        end else if (w_timeout) begin
          w_state_nxt = CLKSW_IDLE;
        end
      end
      CLKSW_SWITCH:  w_state_nxt = CLKSW_SETTLE;
      CLKSW_SETTLE: begin
        if (w_tmr_count <= TIMEOUT_W'(1)) begin
          w_state_nxt = CLKSW_RESTART;
        end
      end
      CLKSW_RESTART: w_state_nxt = CLKSW_IDLE;
      default:       w_state_nxt = CLKSW_IDLE;
    endcase
  end

  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    w_sel_load  = 1'b0;
    w_err_set   = 1'b0;
    w_onoff_nxt = PWM_OFF;
    if ((w_state_nxt == CLKSW_IDLE) || (w_state_nxt == CLKSW_WAIT_BOUND)) begin
      w_onoff_nxt = i_user_onoff;
    end
    case (r_state)
      CLKSW_IDLE: begin
        if (w_state_nxt == CLKSW_WAIT_BOUND) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = i_timeout_cyc;
        end
      end
      CLKSW_WAIT_BOUND, CLKSW_WAIT_IDLE: begin
        w_tmr_dec = 1'b1;
        w_err_set = (w_state_nxt == CLKSW_IDLE);
      end
      CLKSW_SWITCH: begin
        w_sel_load = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = TIMEOUT_W'(SETTLE_CYC);
      end
      CLKSW_SETTLE: w_tmr_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_onoff      <= PWM_OFF;
      r_clk_sel    <= '0;
      r_pend_sel   <= '0;
      r_same_done  <= 1'b0;
      r_err        <= 1'b0;
      r_idle_armed <= 1'b0;
    end else begin
      r_onoff      <= w_onoff_nxt;
      r_same_done  <= w_same;
      r_err        <= w_err_set;
      // pwm_idle in the first WAIT_IDLE cycle still reflects the running core.
      r_idle_armed <= (r_state == CLKSW_WAIT_IDLE);
      if (w_accept) begin
        r_pend_sel <= i_req_sel;
      end
      if (w_sel_load) begin
        r_clk_sel <= r_pend_sel;
      end
    end
  end

  assign o_req_ready   = (r_state == CLKSW_IDLE);
  assign o_busy        = (r_state != CLKSW_IDLE);
  assign o_done        = (r_state == CLKSW_RESTART) || r_same_done;
  assign o_err         = r_err;
  assign o_pwm_onoff   = r_onoff;
  assign o_clk_sel_out = r_clk_sel;

endmodule
